// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, scan state enum and the
// row/column-to-code mapping used by the scanner and the mode UIs.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 3;
  localparam int KEY_BITS = KEY_ROWS * KEY_COLS;

  localparam logic [3:0] KEY_ZERO = 4'd0;
  localparam logic [3:0] KEY_DOT  = 4'd1;
  localparam logic [3:0] KEY_DASH = 4'd2;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_BACK = 4'd11;

  typedef enum logic [1:0] {
    ST_COL0 = 2'd0,
    ST_COL1 = 2'd1,
    ST_COL2 = 2'd2,
    ST_EVAL = 2'd3
  } scan_state_t;

  // Telephone layout: rows 0-2 give 1-9, bottom row is '*', '0', '#'.
  function automatic logic [3:0] key_code(input int unsigned row, input int unsigned col);
    logic [3:0] code;
    if (row < 3) begin
      code = 4'(row * 3 + col + 1);
    end else begin
      case (col)
        0:       code = KEY_STAR;
        1:       code = KEY_ZERO;
        default: code = KEY_BACK;
      endcase
    end
    return code;
  endfunction

  // Active-low column drive pattern for a scan state; EVAL drives nothing.
  function automatic logic [2:0] col_drive(input scan_state_t s);
    logic [2:0] drive;
    case (s)
      ST_COL0: drive = 3'b110;
      ST_COL1: drive = 3'b101;
      ST_COL2: drive = 3'b011;
      default: drive = 3'b111;
    endcase
    return drive;
  endfunction

  function automatic logic is_one_hot(input logic [KEY_BITS-1:0] v);
    return (v != '0) && ((v & (v - 12'd1)) == '0);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: the debounced key vector follows the raw frame only
// after DEBOUNCE_FRAMES consecutive identical frames. The change strobe is
// combinational and valid in the frame-strobe cycle, so the consumer can
// register its event in the same edge that updates the debounced vector.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_valid,
  input  logic [KEY_BITS-1:0] raw,
  output logic [KEY_BITS-1:0] debounced,
  output logic                change
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

  logic [KEY_BITS-1:0] prev_raw_q, prev_raw_d;
  logic [KEY_BITS-1:0] deb_q, deb_d;
  logic [CW-1:0]       stable_cnt_q, stable_cnt_d;

  // Stability counting and debounced update, once per completed frame.
  always_comb begin
    prev_raw_d   = prev_raw_q;
    deb_d        = deb_q;
    stable_cnt_d = stable_cnt_q;
    change       = 1'b0;
    if (frame_valid) begin
      if (raw != prev_raw_q) begin
        stable_cnt_d = CW'(1);
      end else if (stable_cnt_q != CNT_MAX) begin
        stable_cnt_d = stable_cnt_q + CW'(1);
      end
      prev_raw_d = raw;
      if ((stable_cnt_d == CNT_MAX) && (raw != deb_q)) begin
        deb_d  = raw;
        change = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_raw_q   <= '0;
      deb_q        <= '0;
      stable_cnt_q <= '0;
    end else begin
      prev_raw_q   <= prev_raw_d;
      deb_q        <= deb_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  assign debounced = deb_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: drives one column at a time, assembles a 12-bit
// pressed-key frame, debounces it and emits one-cycle key events with a code.
// Optional typematic repeat is compiled in with `define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50_000,
  parameter int DEBOUNCE_FRAMES = 5,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic       key_valid,
  output logic [3:0] k_data,
  output logic       key_pressed
);

  // Column dwell below 2 cycles is not supported; clamp rather than misbehave.
  localparam int DIV = (SCAN_DIV < 2) ? 2 : SCAN_DIV;
  localparam int DEB = (DEBOUNCE_FRAMES < 1) ? 1 : DEBOUNCE_FRAMES;
  localparam int DW  = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  scan_state_t         state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic                run_q;
  logic [KEY_BITS-1:0] raw_q, raw_d;
  logic [2:0]          key_col_q, key_col_d;
  logic                frame_strobe;

  logic [KEY_BITS-1:0] deb_q;
  logic [KEY_BITS-1:0] deb_next;
  logic                deb_change;
  logic [3:0]          next_code;
  logic [3:0]          bit_code [KEY_BITS];
  logic                rep_fire;

  logic                key_valid_q, key_valid_d;
  logic [3:0]          k_data_q, k_data_d;
  logic                key_pressed_q, key_pressed_d;

  // Scan FSM next state, divider and row sampling on the last cycle of each column.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    raw_d        = raw_q;
    frame_strobe = 1'b0;
    if (run_q) begin
      case (state_q)
        ST_COL0: begin
          if (div_q == DIV_LAST) begin
            div_d      = '0;
            raw_d[3:0] = ~key_row;
            state_d    = ST_COL1;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        ST_COL1: begin
          if (div_q == DIV_LAST) begin
            div_d      = '0;
            raw_d[7:4] = ~key_row;
            state_d    = ST_COL2;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        ST_COL2: begin
          if (div_q == DIV_LAST) begin
            div_d       = '0;
            raw_d[11:8] = ~key_row;
            state_d     = ST_EVAL;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
        default: begin
          frame_strobe = 1'b1;
          state_d      = ST_COL0;
        end
      endcase
    end
    // Column drive is registered from the next state so it lines up with state_q.
    key_col_d = col_drive(state_d);
  end

  // Scan registers; run_q holds the FSM in COL0 for the cycle reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_COL0;
      div_q     <= '0;
      run_q     <= 1'b0;
      raw_q     <= '0;
      key_col_q <= 3'b111;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      run_q     <= 1'b1;
      raw_q     <= raw_d;
      key_col_q <= key_col_d;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEB)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_valid(frame_strobe),
    .raw        (raw_q),
    .debounced  (deb_q),
    .change     (deb_change)
  );

  // On a change the debounced vector becomes the raw frame at this edge.
  assign deb_next = deb_change ? raw_q : deb_q;

  // Per-key code contribution; at most one contributes when deb_next is one-hot.
  genvar gi;
  for (gi = 0; gi < KEY_BITS; gi++) begin : g_code
    assign bit_code[gi] = deb_next[gi] ? key_code(gi % KEY_ROWS, gi / KEY_ROWS) : 4'd0;
  end

  // OR-combine the per-key codes into the single-key code.
  always_comb begin
    next_code = 4'd0;
    for (int i = 0; i < KEY_BITS; i++) begin
      next_code = next_code | bit_code[i];
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;

  // Frames a single debounced key has been held; fires at DELAY, then every PERIOD.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    if (frame_strobe) begin
      if (deb_change || !is_one_hot(deb_q)) begin
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
        if (rep_cnt_d == REP_FIRST) begin
          rep_fire = 1'b1;
        end else if (rep_cnt_d == REP_NEXT) begin
          rep_fire  = 1'b1;
          rep_cnt_d = REP_FIRST;
        end
      end
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  assign rep_fire = 1'b0;
  // Without repeat the interval parameters only appear in this empty scope.
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_repeat_cfg_unused
  end
`endif

  // Event decision at EVAL: pulse on a change to exactly one key, or on repeat.
  always_comb begin
    key_valid_d   = 1'b0;
    k_data_d      = k_data_q;
    key_pressed_d = key_pressed_q;
    if (frame_strobe) begin
      key_pressed_d = |deb_next;
      if (deb_change && is_one_hot(deb_next)) begin
        key_valid_d = 1'b1;
        k_data_d    = next_code;
      end else if (rep_fire) begin
        key_valid_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q   <= 1'b0;
      k_data_q      <= 4'd0;
      key_pressed_q <= 1'b0;
    end else begin
      key_valid_q   <= key_valid_d;
      k_data_q      <= k_data_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign key_col     = key_col_q;
  assign key_valid   = key_valid_q;
  assign k_data      = k_data_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and a
// scoreboard of expected key events (code and exact cycle).
`timescale 1ns/1ps
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_FRAMES = 3;
  localparam int REPEAT_DELAY    = 4;
  localparam int REPEAT_PERIOD   = 2;
  localparam int F               = 3 * SCAN_DIV + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_row;
  logic [2:0]  key_col;
  logic        key_valid;
  logic [3:0]  k_data;
  logic        key_pressed;
  logic [11:0] keys = 12'h000;

  typedef struct {
    int code;
    int t;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         t0 = 0;
  bit         started = 1'b0;
  logic [3:0] kd_prev = 4'd0;
  int         mon_t;
  exp_t       mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_row    (key_row),
    .key_col    (key_col),
    .key_valid  (key_valid),
    .k_data     (k_data),
    .key_pressed(key_pressed)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    key_row = 4'hF;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && !key_col[c]) key_row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d at t=%0d", tag, obs, expv, cyc - t0);
    end
  endtask

  task automatic goto(input int t);
    while ((cyc - t0) < t) @(negedge clk);
  endtask

  task automatic push(input int code, input int t);
    exp_t e;
    e.code = code;
    e.t    = t;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every key_valid must match the next expected event exactly.
  always @(negedge clk) begin
    if (started) begin
      mon_t = cyc - t0;
      while (exp_q.size() > 0 && exp_q[0].t < mon_t) begin
        check("pulse_missing", 32'(mon_t), 32'(exp_q[0].t));
        void'(exp_q.pop_front());
      end
      if (key_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(key_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_time", 32'(mon_t), 32'(mon_e.t));
          check("pulse_code", 32'(k_data), 32'(mon_e.code));
          $display("event t=%0d k_data=%0d expected code=%0d at t=%0d", mon_t, k_data, mon_e.code, mon_e.t);
        end
      end
      if (k_data !== kd_prev) check("kdata_change_needs_valid", 32'(key_valid), 32'd1);
      kd_prev = k_data;
    end
  end

  initial begin
    rst  = 1'b1;
    keys = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_key_col", 32'(key_col), 32'(3'b111));
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_k_data", 32'(k_data), 32'd0);
    check("rst_key_pressed", 32'(key_pressed), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    t0      = cyc;
    kd_prev = k_data;
    started = 1'b1;
    check("col0_after_release", 32'(key_col), 32'(3'b110));

    // Bounce: '*' on alternating frames, then idle.
    keys = 12'h008;
    goto(3);  check("col0_last", 32'(key_col), 32'(3'b110));
    goto(4);  check("col1_first", 32'(key_col), 32'(3'b101));
    goto(8);  check("col2_first", 32'(key_col), 32'(3'b011));
    goto(12); check("eval_cols_off", 32'(key_col), 32'(3'b111));
    goto(13); check("frame1_col0", 32'(key_col), 32'(3'b110));
    for (int k = 1; k < 10; k++) begin
      goto(F * k);
      keys = (k < 8 && (k % 2) == 0) ? 12'h008 : 12'h000;
      check("bounce_pressed", 32'(key_pressed), 32'd0);
      check("bounce_k_data", 32'(k_data), 32'd0);
    end

    // Single press of '1' for 5 frames, then release.
    goto(F * 10);
    keys = 12'h001;
    push(KEY_DOT, F * 13);
`ifdef KEYPAD_REPEAT_EN
    push(KEY_DOT, F * 17);
`endif
    goto(F * 13 - 1); check("press1_pressed_before", 32'(key_pressed), 32'd0);
    goto(F * 13);     check("press1_pressed", 32'(key_pressed), 32'd1);
                      check("press1_k_data", 32'(k_data), 32'(KEY_DOT));
    goto(F * 15);     keys = 12'h000;
    goto(F * 18 - 1); check("release1_still_pressed", 32'(key_pressed), 32'd1);
    goto(F * 18);     check("release1_pressed", 32'(key_pressed), 32'd0);

    // Multi-key '1'+'2', then roll-over to '2' alone (held long for repeat).
    goto(F * 20);     keys = 12'h011;
    goto(F * 23 - 1); check("multi_pressed_before", 32'(key_pressed), 32'd0);
    goto(F * 23);     check("multi_pressed", 32'(key_pressed), 32'd1);
                      check("multi_k_data", 32'(k_data), 32'(KEY_DOT));
    goto(F * 26);     keys = 12'h010;
    push(KEY_DASH, F * 29);
`ifdef KEYPAD_REPEAT_EN
    for (int i = 0; i < 6; i++) push(KEY_DASH, F * (33 + 2 * i));
`endif
    goto(F * 29 - 1); check("rollover_k_data_before", 32'(k_data), 32'(KEY_DOT));
    goto(F * 29);     check("rollover_k_data", 32'(k_data), 32'(KEY_DASH));
                      check("rollover_pressed", 32'(key_pressed), 32'd1);
    goto(F * 41);     keys = 12'h000;
    goto(F * 44 - 1); check("release2_still_pressed", 32'(key_pressed), 32'd1);
    goto(F * 44);     check("release2_pressed", 32'(key_pressed), 32'd0);

    // Code map: '#' then '0'.
    goto(F * 45);     keys = 12'h800;
    push(KEY_BACK, F * 48);
`ifdef KEYPAD_REPEAT_EN
    push(KEY_BACK, F * 52);
`endif
    goto(F * 48);     check("hash_k_data", 32'(k_data), 32'(KEY_BACK));
    goto(F * 50);     keys = 12'h000;
    goto(F * 53);     keys = 12'h080;
    push(KEY_ZERO, F * 56);
`ifdef KEYPAD_REPEAT_EN
    push(KEY_ZERO, F * 60);
`endif
    goto(F * 56 - 1); check("zero_k_data_before", 32'(k_data), 32'(KEY_BACK));
    goto(F * 56);     check("zero_k_data", 32'(k_data), 32'(KEY_ZERO));
                      check("zero_pressed", 32'(key_pressed), 32'd1);
    goto(F * 58);     keys = 12'h000;
    goto(F * 61 - 1); check("release0_still_pressed", 32'(key_pressed), 32'd1);
    goto(F * 61);     check("release0_pressed", 32'(key_pressed), 32'd0);
    goto(F * 62);
    check("events_outstanding", 32'(exp_q.size()), 32'd0);
    check("final_k_data", 32'(k_data), 32'(KEY_ZERO));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
